// File: rtl/fu_issue_dispatch.sv
// Issue stage: holds one decoded instruction and dispatches it
// to its functional unit with a one-hot valid strobe.
module fu_issue_dispatch #(
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  input  logic [3:0]               instr_fu_i,
  input  logic [7:0]               instr_op_i,
  input  logic [XLEN-1:0]          instr_op_a_i,
  input  logic [XLEN-1:0]          instr_op_b_i,
  input  logic [XLEN-1:0]          instr_imm_i,
  input  logic [TRANS_ID_BITS-1:0] instr_trans_id_i,
  output logic [7:0]               fu_op_o,
  output logic [XLEN-1:0]          fu_op_a_o,
  output logic [XLEN-1:0]          fu_op_b_o,
  output logic [XLEN-1:0]          fu_imm_o,
  output logic [TRANS_ID_BITS-1:0] fu_trans_id_o,
  output logic                     alu_valid_o,
  output logic                     branch_valid_o,
  output logic                     csr_valid_o,
  output logic                     mult_valid_o,
  output logic                     lsu_valid_o,
  output logic                     fpu_valid_o,
  output logic                     x_valid_o,
  input  logic                     flu_ready_i,
  input  logic                     lsu_ready_i,
  input  logic                     fpu_ready_i,
  input  logic                     x_ready_i,
  input  logic                     csr_commit_i,
  output logic [15:0]              stall_cnt_o
);

  localparam logic [3:0] FU_LOAD  = 4'd1;
  localparam logic [3:0] FU_STORE = 4'd2;
  localparam logic [3:0] FU_ALU   = 4'd3;
  localparam logic [3:0] FU_CTRL  = 4'd4;
  localparam logic [3:0] FU_MULT  = 4'd5;
  localparam logic [3:0] FU_CSR   = 4'd6;
  localparam logic [3:0] FU_FPU   = 4'd7;
  localparam logic [3:0] FU_CVXIF = 4'd9;

  typedef enum logic {
    IDLE,
    CSR_WAIT
  } state_e;

  state_e     state_q, state_d;
  logic       valid_q;
  logic       mult_issued_q;
  logic [3:0] fu_q;
  logic       unit_ready;
  logic       hazard;
  logic       fire;
  logic       accept;
  logic       is_alu, is_br, is_csr, is_mul;
  logic       is_lsu, is_fpu, is_x;

  // Decode the held unit code into a unit class and its readiness.
  always_comb begin
    unit_ready = 1'b1;
    is_alu     = 1'b0;
    is_br      = 1'b0;
    is_csr     = 1'b0;
    is_mul     = 1'b0;
    is_lsu     = 1'b0;
    is_fpu     = 1'b0;
    is_x       = 1'b0;
    case (fu_q)
      FU_ALU: begin
        is_alu     = 1'b1;
        unit_ready = flu_ready_i;
      end
      FU_CTRL: begin
        is_br      = 1'b1;
        unit_ready = flu_ready_i;
      end
      FU_CSR: begin
        is_csr     = 1'b1;
        unit_ready = flu_ready_i;
      end
      FU_MULT: begin
        is_mul     = 1'b1;
        unit_ready = flu_ready_i;
      end
      FU_LOAD, FU_STORE: begin
        is_lsu     = 1'b1;
        unit_ready = lsu_ready_i;
      end
      FU_FPU: begin
        is_fpu     = 1'b1;
        unit_ready = fpu_ready_i;
      end
      FU_CVXIF: begin
        is_x       = 1'b1;
        unit_ready = x_ready_i;
      end
      default: ;
    endcase
  end

  // A multiply blocks the flu-shared units for one cycle after issue.
  assign hazard = mult_issued_q && (is_alu || is_br || is_csr);
  assign fire   = valid_q && unit_ready && (state_q == IDLE)
               && !hazard && !flush_i;

  assign instr_ready_o = !flush_i && (!valid_q || fire);
  assign accept        = instr_valid_i && instr_ready_o;

  assign alu_valid_o    = fire && is_alu;
  assign branch_valid_o = fire && is_br;
  assign csr_valid_o    = fire && is_csr;
  assign mult_valid_o   = fire && is_mul;
  assign lsu_valid_o    = fire && is_lsu;
  assign fpu_valid_o    = fire && is_fpu;
  assign x_valid_o      = fire && is_x;

  // Next-state logic for the CSR commit wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (fire && is_csr) state_d = CSR_WAIT;
      CSR_WAIT: if (csr_commit_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Issue register: valid flag, payload and multiply-shadow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q       <= 1'b0;
      mult_issued_q <= 1'b0;
      fu_q          <= '0;
      fu_op_o       <= '0;
      fu_op_a_o     <= '0;
      fu_op_b_o     <= '0;
      fu_imm_o      <= '0;
      fu_trans_id_o <= '0;
    end else begin
      mult_issued_q <= fire && is_mul;
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q       <= 1'b1;
        fu_q          <= instr_fu_i;
        fu_op_o       <= instr_op_i;
        fu_op_a_o     <= instr_op_a_i;
        fu_op_b_o     <= instr_op_b_i;
        fu_imm_o      <= instr_imm_i;
        fu_trans_id_o <= instr_trans_id_i;
      end else if (fire) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Saturating count of cycles spent holding an unissued instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      stall_cnt_o <= '0;
    else if (valid_q && !fire && stall_cnt_o != 16'hFFFF)
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end

endmodule

// File: tb/tb_fu_issue_dispatch.sv
// Bench for fu_issue_dispatch: scoreboard of expected issues
// plus directed cycle checks.
module tb_fu_issue_dispatch;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [3:0]  instr_fu_i;
  logic [7:0]  instr_op_i;
  logic [63:0] instr_op_a_i;
  logic [63:0] instr_op_b_i;
  logic [63:0] instr_imm_i;
  logic [2:0]  instr_trans_id_i;
  logic [7:0]  fu_op_o;
  logic [63:0] fu_op_a_o;
  logic [63:0] fu_op_b_o;
  logic [63:0] fu_imm_o;
  logic [2:0]  fu_trans_id_o;
  logic        alu_valid_o, branch_valid_o, csr_valid_o;
  logic        mult_valid_o, lsu_valid_o, fpu_valid_o, x_valid_o;
  logic        flu_ready_i, lsu_ready_i, fpu_ready_i, x_ready_i;
  logic        csr_commit_i;
  logic [15:0] stall_cnt_o;
  logic [6:0]  stb;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int unsigned unit;
    logic [2:0]  id;
  } exp_t;
  exp_t sb[$];

  localparam int U_ALU = 0, U_BR = 1, U_CSR = 2, U_MUL = 3;
  localparam int U_LSU = 4, U_FPU = 5, U_X = 6;
  localparam logic [3:0] F_LOAD = 4'd1, F_ALU = 4'd3;
  localparam logic [3:0] F_MULT = 4'd5, F_CSR = 4'd6, F_FPU = 4'd7;

  fu_issue_dispatch #(.TRANS_ID_BITS(3), .XLEN(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_fu_i(instr_fu_i), .instr_op_i(instr_op_i),
    .instr_op_a_i(instr_op_a_i), .instr_op_b_i(instr_op_b_i),
    .instr_imm_i(instr_imm_i), .instr_trans_id_i(instr_trans_id_i),
    .fu_op_o(fu_op_o), .fu_op_a_o(fu_op_a_o), .fu_op_b_o(fu_op_b_o),
    .fu_imm_o(fu_imm_o), .fu_trans_id_o(fu_trans_id_o),
    .alu_valid_o(alu_valid_o), .branch_valid_o(branch_valid_o),
    .csr_valid_o(csr_valid_o), .mult_valid_o(mult_valid_o),
    .lsu_valid_o(lsu_valid_o), .fpu_valid_o(fpu_valid_o),
    .x_valid_o(x_valid_o), .flu_ready_i(flu_ready_i),
    .lsu_ready_i(lsu_ready_i), .fpu_ready_i(fpu_ready_i),
    .x_ready_i(x_ready_i), .csr_commit_i(csr_commit_i),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  assign stb = {x_valid_o, fpu_valid_o, lsu_valid_o, mult_valid_o,
                csr_valid_o, branch_valid_o, alu_valid_o};

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic issue(logic [3:0] fu, logic [2:0] id);
    instr_valid_i    = 1'b1;
    instr_fu_i       = fu;
    instr_trans_id_i = id;
    instr_op_i       = {fu, 1'b0, id};
    instr_op_a_i     = 64'hA000_0000_0000_0000 | 64'(id);
    instr_op_b_i     = 64'hB000_0000_0000_0000 | 64'(fu);
    instr_imm_i      = 64'h0000_0000_C0DE_0000 | 64'(id);
  endtask

  task automatic idle();
    instr_valid_i = 1'b0;
  endtask

  task automatic push(int unsigned u, logic [2:0] id);
    exp_t e;
    e.unit = u;
    e.id   = id;
    sb.push_back(e);
  endtask

  // Scoreboard side: every strobe must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni && stb != 7'd0) begin
      chk("onehot", 64'($countones(stb)), 64'd1);
      if (sb.size() == 0) begin
        chk("unexpected_issue", 64'(stb), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_unit", 64'(stb), 64'(7'd1 << e.unit));
        chk("sb_tid", 64'(fu_trans_id_o), 64'(e.id));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    flush_i = 1'b0;
    csr_commit_i = 1'b0;
    flu_ready_i = 1'b1;
    lsu_ready_i = 1'b1;
    fpu_ready_i = 1'b1;
    x_ready_i = 1'b1;
    instr_valid_i = 1'b0;
    instr_fu_i = '0;
    instr_op_i = '0;
    instr_op_a_i = '0;
    instr_op_b_i = '0;
    instr_imm_i = '0;
    instr_trans_id_i = '0;

    tick(); smp();
    chk("rst_stb", 64'(stb), 64'd0);
    chk("rst_op", 64'(fu_op_o), 64'd0);
    chk("rst_opa", fu_op_a_o, 64'd0);
    chk("rst_tid", 64'(fu_trans_id_o), 64'd0);
    chk("rst_stall", 64'(stall_cnt_o), 64'd0);
    tick(); rst_ni = 1'b1;

    // back-to-back ALU
    tick(); issue(F_ALU, 3'd1); push(U_ALU, 3'd1);
    smp(); chk("b2b_rdy0", 64'(instr_ready_o), 64'd1);
    tick(); issue(F_ALU, 3'd2); push(U_ALU, 3'd2);
    smp(); chk("b2b_alu1", 64'(alu_valid_o), 64'd1);
    chk("b2b_tid1", 64'(fu_trans_id_o), 64'd1);
    chk("b2b_rdy1", 64'(instr_ready_o), 64'd1);
    tick(); idle();
    smp(); chk("b2b_alu2", 64'(alu_valid_o), 64'd1);
    chk("b2b_tid2", 64'(fu_trans_id_o), 64'd2);
    chk("b2b_rdy2", 64'(instr_ready_o), 64'd1);

    // MULT then ALU: one-cycle hazard
    tick(); issue(F_MULT, 3'd3); push(U_MUL, 3'd3);
    smp();
    tick(); issue(F_ALU, 3'd4); push(U_ALU, 3'd4);
    smp(); chk("mh_mul", 64'(mult_valid_o), 64'd1);
    tick(); idle();
    smp(); chk("mh_none", 64'(stb), 64'd0);
    chk("mh_rdy", 64'(instr_ready_o), 64'd0);
    tick();
    smp(); chk("mh_alu", 64'(alu_valid_o), 64'd1);
    chk("mh_tid", 64'(fu_trans_id_o), 64'd4);
    tick();
    smp(); chk("mh_stall", 64'(stall_cnt_o), 64'd1);

    // MULT then LOAD: no hazard
    tick(); issue(F_MULT, 3'd5); push(U_MUL, 3'd5);
    smp();
    tick(); issue(F_LOAD, 3'd6); push(U_LSU, 3'd6);
    smp(); chk("ml_mul", 64'(mult_valid_o), 64'd1);
    tick(); idle();
    smp(); chk("ml_lsu", 64'(lsu_valid_o), 64'd1);
    chk("ml_tid", 64'(fu_trans_id_o), 64'd6);
    chk("ml_stall", 64'(stall_cnt_o), 64'd1);

    // CSR wait, ALU queued, commit in cycle 4
    tick(); issue(F_CSR, 3'd5); push(U_CSR, 3'd5);
    smp();
    tick(); issue(F_ALU, 3'd7); push(U_ALU, 3'd7);
    smp(); chk("csr_fire", 64'(csr_valid_o), 64'd1);
    chk("csr_rdy1", 64'(instr_ready_o), 64'd1);
    tick(); idle();
    smp(); chk("csr_rdy2", 64'(instr_ready_o), 64'd0);
    chk("csr_alu2", 64'(alu_valid_o), 64'd0);
    tick();
    smp(); chk("csr_rdy3", 64'(instr_ready_o), 64'd0);
    tick(); csr_commit_i = 1'b1;
    smp(); chk("csr_rdy4", 64'(instr_ready_o), 64'd0);
    chk("csr_alu4", 64'(alu_valid_o), 64'd0);
    tick(); csr_commit_i = 1'b0;
    smp(); chk("csr_alu5", 64'(alu_valid_o), 64'd1);
    chk("csr_tid5", 64'(fu_trans_id_o), 64'd7);
    tick();
    smp(); chk("csr_stall", 64'(stall_cnt_o), 64'd4);

    // long LOAD stall, counter saturates
    tick(); lsu_ready_i = 1'b0; issue(F_LOAD, 3'd2); push(U_LSU, 3'd2);
    smp();
    tick(); idle();
    for (int i = 0; i < 70000; i++) begin
      smp();
      if (i % 8192 == 0) begin
        chk("hold_lsu", 64'(lsu_valid_o), 64'd0);
        chk("hold_opa", fu_op_a_o, 64'hA000_0000_0000_0002);
        chk("hold_imm", fu_imm_o, 64'h0000_0000_C0DE_0002);
      end
      tick();
    end
    lsu_ready_i = 1'b1;
    smp(); chk("hold_fire", 64'(lsu_valid_o), 64'd1);
    chk("hold_opb", fu_op_b_o, 64'hB000_0000_0000_0001);
    chk("hold_sat", 64'(stall_cnt_o), 64'hFFFF);
    tick();
    smp(); chk("sat_keep", 64'(stall_cnt_o), 64'hFFFF);

    // flush against a ready FPU op
    tick(); issue(F_FPU, 3'd3);
    smp();
    tick(); idle(); flush_i = 1'b1;
    smp(); chk("fl_fpu", 64'(fpu_valid_o), 64'd0);
    chk("fl_rdy", 64'(instr_ready_o), 64'd0);
    tick(); flush_i = 1'b0;
    smp(); chk("fl_fpu_n", 64'(fpu_valid_o), 64'd0);
    chk("fl_rdy_n", 64'(instr_ready_o), 64'd1);

    // flush during CSR wait
    tick(); issue(F_CSR, 3'd1); push(U_CSR, 3'd1);
    smp();
    tick(); idle();
    smp(); chk("fc_csr", 64'(csr_valid_o), 64'd1);
    tick();
    smp(); chk("fc_wait", 64'(instr_ready_o), 64'd1);
    tick(); flush_i = 1'b1;
    smp(); chk("fc_rdy", 64'(instr_ready_o), 64'd0);
    tick(); flush_i = 1'b0; issue(F_ALU, 3'd2); push(U_ALU, 3'd2);
    smp(); chk("fc_rdy_n", 64'(instr_ready_o), 64'd1);
    tick(); idle();
    smp(); chk("fc_alu", 64'(alu_valid_o), 64'd1);

    // unknown unit code acts as NONE: consumed, no strobe
    tick(); issue(4'd12, 3'd3);
    smp();
    tick(); idle();
    smp(); chk("none_stb", 64'(stb), 64'd0);
    chk("none_rdy", 64'(instr_ready_o), 64'd1);

    // reset during CSR wait with a held MULT
    tick(); issue(F_CSR, 3'd4); push(U_CSR, 3'd4);
    smp();
    tick(); issue(F_MULT, 3'd5);
    smp(); chk("rw_csr", 64'(csr_valid_o), 64'd1);
    tick(); idle();
    smp(); chk("rw_rdy", 64'(instr_ready_o), 64'd0);
    chk("rw_mul", 64'(mult_valid_o), 64'd0);
    tick(); rst_ni = 1'b0;
    smp(); chk("rw_stb", 64'(stb), 64'd0);
    chk("rw_op", 64'(fu_op_o), 64'd0);
    chk("rw_opa", fu_op_a_o, 64'd0);
    chk("rw_opb", fu_op_b_o, 64'd0);
    chk("rw_imm", fu_imm_o, 64'd0);
    chk("rw_tid", 64'(fu_trans_id_o), 64'd0);
    chk("rw_stall", 64'(stall_cnt_o), 64'd0);
    tick(); rst_ni = 1'b1;
    smp(); chk("rw_rdy_n", 64'(instr_ready_o), 64'd1);
    chk("rw_mul_n", 64'(mult_valid_o), 64'd0);
    tick(); issue(F_ALU, 3'd6); push(U_ALU, 3'd6);
    smp();
    tick(); idle();
    smp(); chk("rw_alu", 64'(alu_valid_o), 64'd1);
    tick();
    smp(); chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("end_stall", 64'(stall_cnt_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fu_issue_dispatch.md
FU_ISSUE_DISPATCH -- requirements
Module: fu_issue_dispatch

Interface
REQ-001 SHALL have parameter TRANS_ID_BITS, default 3, meaning the scoreboard transaction-id width.
REQ-002 SHALL have parameter XLEN, default 64, meaning the operand width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush_i, input, 1, which kills the held instruction and any wait state.
REQ-006 SHALL have port instr_valid_i, input, 1, meaning the upstream instruction is valid.
REQ-007 SHALL have port instr_ready_o, output, 1, meaning the block accepts the upstream instruction this cycle.
REQ-008 SHALL have port instr_fu_i, input, 4, the unit code: 0 NONE, 1 LOAD, 2 STORE, 3 ALU, 4 CTRL_FLOW, 5 MULT, 6 CSR, 7 FPU, 9 CVXIF; all other codes are treated as NONE.
REQ-009 SHALL have ports instr_op_i (input, 8), instr_op_a_i / instr_op_b_i / instr_imm_i (input, XLEN) and instr_trans_id_i (input, TRANS_ID_BITS), which form the operation payload.
REQ-010 SHALL have ports fu_op_o, fu_op_a_o, fu_op_b_o, fu_imm_o and fu_trans_id_o, outputs matching the REQ-009 widths, carrying the registered payload.
REQ-011 SHALL have ports alu_valid_o, branch_valid_o, csr_valid_o, mult_valid_o, lsu_valid_o, fpu_valid_o and x_valid_o, each an output of width 1 acting as a one-hot issue strobe.
REQ-012 SHALL have ports flu_ready_i, lsu_ready_i, fpu_ready_i and x_ready_i, each an input of width 1 giving unit readiness.
REQ-013 SHALL have port csr_commit_i, input, 1, meaning the issued CSR instruction has committed.
REQ-014 SHALL have port stall_cnt_o, output, 16, a saturating count of stall cycles.

Function
REQ-015 SHALL hold one instruction in an issue register; valid_q is set when instr_valid_i && instr_ready_o.
REQ-016 SHALL compute instr_ready_o = !valid_q || fire, where fire is the issue of the held instruction in the current cycle; the minimum latency from accept to strobe is 1 cycle.
REQ-017 SHALL define unit_ready as follows:
- ALU, CTRL_FLOW, CSR, MULT -> flu_ready_i
- LOAD, STORE -> lsu_ready_i
- FPU -> fpu_ready_i
- CVXIF -> x_ready_i
- NONE -> 1
REQ-018 SHALL define fire = valid_q && unit_ready && state==IDLE && !hazard.
REQ-019 SHALL assert the matching strobe combinationally only in a fire cycle:
- LOAD/STORE -> lsu_valid_o
- CTRL_FLOW -> branch_valid_o
- NONE -> no strobe; the instruction is still consumed.
REQ-020 SHALL, on fire of MULT, set mult_issued_q for exactly the next cycle.
REQ-021 SHALL set hazard = mult_issued_q && fu in {ALU, CTRL_FLOW, CSR}; MULT, LOAD, STORE, FPU and CVXIF are not blocked by the hazard.
REQ-022 SHALL implement states IDLE and CSR_WAIT, with these transitions:
- IDLE -> CSR_WAIT on fire of CSR
- CSR_WAIT -> IDLE on csr_commit_i or on flush_i
- csr_commit_i in IDLE is ignored.
REQ-023 SHALL issue nothing while in CSR_WAIT; a new instruction may still be accepted only if valid_q is 0.
REQ-024 SHALL give flush_i priority over all events; in the flush cycle it:
- clears valid_q and mult_issued_q
- forces IDLE
- drives all strobes 0
- drives instr_ready_o 0.
REQ-025 SHALL increment stall_cnt_o in every cycle with valid_q && !fire and saturate it at 16'hFFFF; flush_i does not clear it.
REQ-026 SHALL hold the payload outputs stable while valid_q && !fire, with no payload change without a fire or flush.

Reset
REQ-027 SHALL, while rst_ni is low:
- clear valid_q, mult_issued_q and stall_cnt_o
- set state to IDLE
- drive all strobes 0 and all payload outputs 0.
REQ-028 SHALL, on reset asserted mid-operation (including in CSR_WAIT), discard the held instruction and drive instr_ready_o 1 in the first cycle after deassertion.

Verification
REQ-029 SHALL be checked with back-to-back ALU ops (trans_id 1, 2), flu_ready_i=1 -> alu_valid_o high in cycles 1 and 2 with fu_trans_id_o 1 then 2, and instr_ready_o constantly 1.
REQ-030 SHALL be checked with MULT (id 3) followed by ALU (id 4) -> mult_valid_o in cycle 1, no strobe in cycle 2, alu_valid_o in cycle 3, stall_cnt_o=1; MULT followed by LOAD -> lsu_valid_o in cycle 2.
REQ-031 SHALL be checked with CSR (id 5), then ALU queued, csr_commit_i pulsed in cycle 4 -> csr_valid_o in cycle 1, alu_valid_o in cycle 5, instr_ready_o 0 in cycles 2-4.
REQ-032 SHALL be checked with LOAD held while lsu_ready_i=0 for 70000 cycles -> payload stable, stall_cnt_o=16'hFFFF, lsu_valid_o in the first cycle lsu_ready_i=1.
REQ-033 SHALL be checked with flush_i in the same cycle as a ready FPU op, and flush_i during CSR_WAIT -> no fpu_valid_o, valid_q=0, state IDLE, and instr_ready_o=1 in the next cycle.
REQ-034 SHALL be checked with rst_ni pulsed low while in CSR_WAIT with a held MULT -> all outputs 0 and the MULT never issued.
